addsub_pipe: RTL and testbench

//  Parametrised successor to the 10-bit enabled full adder: a pipelined add/subtract unit with

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_seg_stage.sv | 55 +++++
 rtl/addsub_pipe.sv | 105 ++++++++++
 tb/tb_addsub_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the segmented add/subtract pipeline.
// Provides the operation encoding and the ceil-divide used for stage count.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int nseg(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

endpackage

// File: rtl/addsub_seg_stage.sv
// One registered adder slice: resolves segment IDX plus the incoming carry.
// Ports: clk/rst/en, input bundle (vld,a,b,res,carry), registered copy (*_q).
module addsub_seg_stage #(
  parameter int WIDTH = 10,
  parameter int SEG_W = 5,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] res,
  input  logic             carry,
  output logic             vld_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] res_q,
  output logic             carry_q
);

  localparam int LO = IDX * SEG_W;
  localparam int HI = (LO + SEG_W > WIDTH) ? WIDTH - 1 : LO + SEG_W - 1;
  localparam int SW = HI - LO + 1;

  logic [SW:0]      seg_sum;
  logic [WIDTH-1:0] res_next;

  assign seg_sum = {1'b0, a[HI:LO]}
                 + {1'b0, b[HI:LO]}
                 + {{SW{1'b0}}, carry};

  always_comb begin
    res_next        = res;
    res_next[HI:LO] = seg_sum[SW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      vld_q   <= vld;
      a_q     <= a;
      b_q     <= b;
      res_q   <= res_next;
      carry_q <= seg_sum[SW];
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with valid/ready, carry-out and signed overflow.
// Ports: i_clk,i_rst,i_valid,o_ready,i_sub,i_a,i_b,i_cin / o_valid,i_ready,
// o_result,o_cout,o_ovf. Define SATURATE_EN to clamp overflowed results.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int SEG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  op_e              op;
  logic [WIDTH-1:0] b_op;
  logic             c_op;
  logic             en;

  logic             vld_s [NSEG+1];
  logic [WIDTH-1:0] a_s   [NSEG+1];
  logic [WIDTH-1:0] b_s   [NSEG+1];
  logic [WIDTH-1:0] r_s   [NSEG+1];
  logic             c_s   [NSEG+1];

  assign op = op_e'(i_sub);

  // Subtraction is A + ~B + ~cin, so borrow-in maps onto carry-in.
  always_comb begin
    b_op = i_b;
    c_op = i_cin;
    if (op == OP_SUB) begin
      b_op = ~i_b;
      c_op = ~i_cin;
    end
  end

  assign vld_s[0] = i_valid;
  assign a_s[0]   = i_a;
  assign b_s[0]   = b_op;
  assign r_s[0]   = '0;
  assign c_s[0]   = c_op;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    addsub_seg_stage #(
      .WIDTH(WIDTH),
      .SEG_W(SEG_W),
      .IDX  (k)
    ) u_seg (
      .clk    (i_clk),
      .rst    (i_rst),
      .en     (en),
      .vld    (vld_s[k]),
      .a      (a_s[k]),
      .b      (b_s[k]),
      .res    (r_s[k]),
      .carry  (c_s[k]),
      .vld_q  (vld_s[k+1]),
      .a_q    (a_s[k+1]),
      .b_q    (b_s[k+1]),
      .res_q  (r_s[k+1]),
      .carry_q(c_s[k+1])
    );
  end

  // Whole pipe freezes while the head result waits on the consumer.
  assign o_valid = vld_s[NSEG];
  assign en      = !(o_valid && !i_ready);
  assign o_ready = en;

  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] res;
  logic             unused_bits;

  assign a_msb       = a_s[NSEG][WIDTH-1];
  assign b_msb       = b_s[NSEG][WIDTH-1];
  assign res         = r_s[NSEG];
  assign unused_bits = ^{a_s[NSEG][WIDTH-2:0], b_s[NSEG][WIDTH-2:0]};

  assign o_cout = c_s[NSEG];
  assign o_ovf  = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);

`ifdef SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  assign o_result = o_ovf ? (a_msb ? SMIN : SMAX) : res;
`else
  assign o_result = res;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=10, SEG_W=5).
// Directed vectors with literal expectations plus a queue-based model.
module tb_addsub_pipe;

  localparam int W = 10;
  localparam int M = 1 << W;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_sub = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_cin = 1'b0;
  logic         i_ready = 1'b1;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_result;
  logic         o_cout;
  logic         o_ovf;

  addsub_pipe #(.WIDTH(W), .SEG_W(5)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sub   (i_sub),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit sub;
    int a, b, cin;
    int res, sat, cout, ovf;
  } vec_t;

  vec_t vt[10];
  logic [W+1:0] q[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected {ovf, cout, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input bit sub, input int a,
                                         input int b, input int cin);
    int sa, sb, ures, sres, r;
    bit cout, ovf;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    if (!sub) begin
      ures = a + b + cin;
      sres = sa + sb + cin;
      cout = (ures >= M);
    end else begin
      ures = a - b - cin;
      sres = sa - sb - cin;
      cout = (ures >= 0);
    end
    r   = ((ures % M) + M) % M;
    ovf = (sres > M / 2 - 1) || (sres < -(M / 2));
`ifdef SATURATE_EN
    if (ovf) r = (sres > 0) ? M / 2 - 1 : M / 2;
`endif
    return {ovf, cout, W'(r)};
  endfunction

  function automatic int exp_res(input vec_t v);
`ifdef SATURATE_EN
    return v.sat;
`else
    return v.res;
`endif
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      q.delete();
    end else begin
      if (o_valid && i_ready && q.size() > 0)
        void'(q.pop_front());
      if (i_valid && o_ready)
        q.push_back(model(i_sub, int'(i_a), int'(i_b), int'(i_cin)));
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("ready_rule", int'(o_ready), int'(!(o_valid && !i_ready)));
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", int'(o_valid), 0);
        end else begin
          chk("result", int'(o_result), int'(q[0][W-1:0]));
          chk("cout", int'(o_cout), int'(q[0][W]));
          chk("ovf", int'(o_ovf), int'(q[0][W+1]));
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    n = 0;
    i_sub   = v.sub;
    i_a     = v.a[W-1:0];
    i_b     = v.b[W-1:0];
    i_cin   = v.cin[0];
    i_valid = 1'b1;
    forever begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk);
        #1;
        break;
      end
      @(posedge i_clk);
      #1;
      n++;
      if (n > 50) begin
        chk("send_timeout", int'(o_ready), 1);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] m;
    vt[0] = '{0,   28,   33, 0,   61,   61, 0, 0};
    vt[1] = '{0,   81,   17, 0,   98,   98, 0, 0};
    vt[2] = '{0, 1023,    1, 0,    0,    0, 1, 0};
    vt[3] = '{1,    5,    7, 0, 1022, 1022, 0, 0};
    vt[4] = '{1,    7,    5, 0,    2,    2, 1, 0};
    vt[5] = '{0,  511,    1, 0,  512,  511, 0, 1};
    vt[6] = '{1,  512,    1, 0,  511,  512, 1, 1};
    vt[7] = '{0,  100,  200, 1,  301,  301, 0, 0};
    vt[8] = '{1,    0,    0, 1, 1023, 1023, 0, 0};
    vt[9] = '{0, 1023, 1023, 1, 1023, 1023, 1, 0};

    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_result", int'(o_result), 0);
    chk("rst_cout", int'(o_cout), 0);
    chk("rst_ovf", int'(o_ovf), 0);
    chk("rst_ready", int'(o_ready), 1);

    for (int i = 0; i < 10; i++) begin
      m = model(vt[i].sub, vt[i].a, vt[i].b, vt[i].cin);
      chk($sformatf("pin%0d_res", i), int'(m[W-1:0]), exp_res(vt[i]));
      chk($sformatf("pin%0d_cout", i), int'(m[W]), vt[i].cout);
      chk($sformatf("pin%0d_ovf", i), int'(m[W+1]), vt[i].ovf);
    end

    @(posedge i_clk);
    #1;
    send(vt[0]);
    @(negedge i_clk);
    chk("lat1_valid", int'(o_valid), 0);
    @(negedge i_clk);
    chk("lat2_valid", int'(o_valid), 1);
    chk("lat2_result", int'(o_result), 61);
    idle(3);

    send(vt[1]);
    send(vt[2]);
    @(negedge i_clk);
    chk("b2b_first", int'(o_result), 98);
    @(negedge i_clk);
    chk("b2b_second", int'(o_result), 0);
    chk("b2b_cout", int'(o_cout), 1);
    idle(3);

    send(vt[3]);
    send(vt[4]);
    idle(4);
    send(vt[5]);
    send(vt[6]);
    idle(4);

    send(vt[0]);
    send(vt[1]);
    i_ready = 1'b0;
    fork
      send(vt[7]);
      begin
        repeat (3) begin
          @(negedge i_clk);
          chk("stall_ready", int'(o_ready), 0);
          chk("stall_valid", int'(o_valid), 1);
          chk("stall_hold", int'(o_result), 61);
        end
        i_ready = 1'b1;
      end
    join
    idle(5);

    send(vt[8]);
    send(vt[9]);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("flush_valid", int'(o_valid), 0);
    chk("flush_result", int'(o_result), 0);
    chk("flush_cout", int'(o_cout), 0);
    chk("flush_ovf", int'(o_ovf), 0);
    chk("flush_ready", int'(o_ready), 1);
    repeat (4) begin
      @(negedge i_clk);
      chk("flush_quiet", int'(o_valid), 0);
    end
    @(posedge i_clk);
    #1;

    send(vt[7]);
    idle(5);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
